// File: rtl/mxv_pkg.sv
// Shared constants and state encoding for the
// matrix-vector command controller.
package mxv_pkg;

  localparam logic [7:0] HDR = 8'hFE;
  localparam logic [7:0] TRL = 8'hEF;

  localparam logic [7:0] CMD_SIZE  = 8'h01;
  localparam logic [7:0] CMD_VEC   = 8'h02;
  localparam logic [7:0] CMD_MAT   = 8'h03;
  localparam logic [7:0] CMD_START = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_CMD,
    S_PAYLOAD,
    S_TRAIL,
    S_EXEC,
    S_ERR
  } state_t;

endpackage

// File: rtl/mxv_cmd_ctrl_if.sv
// Character input and command/element output bundle
// of the matrix-vector command controller.
interface mxv_cmd_ctrl_if #(
  parameter int DW    = 8,
  parameter int MAX_N = 8,
  parameter int N_CH  = 4
);
  localparam int SW = $clog2(MAX_N + 1);

  logic            rcv;
  logic [7:0]      data;
  logic            push_vector;
  logic [N_CH-1:0] push_matrix;
  logic [DW-1:0]   val;
  logic [N_CH-1:0] ena_proc;
  logic [SW-1:0]   size;
  logic            busy;
  logic            err;

  modport master (
    output rcv, data,
    input  push_vector, push_matrix, val,
    input  ena_proc, size, busy, err
  );

  modport slave (
    input  rcv, data,
    output push_vector, push_matrix, val,
    output ena_proc, size, busy, err
  );
endinterface

// File: rtl/ascii_byte_asm.sv
// Assembles pairs of ASCII hex characters into bytes,
// high nibble first; flags any non-hex character.
module ascii_byte_asm (
  input  logic       clk,
  input  logic       rst,
  input  logic       rcv,
  input  logic [7:0] data,
  output logic       byte_vld,
  output logic [7:0] byte_val,
  output logic       bad
);
  logic       hex;
  logic [3:0] nib;
  logic       phase;
  logic [3:0] hi;

  always_comb begin
    hex = 1'b1;
    nib = '0;
    unique case (1'b1)
      (data >= 8'h30 && data <= 8'h39):
        nib = data[3:0];
      (data >= 8'h41 && data <= 8'h46):
        nib = data[3:0] + 4'd9;
      (data >= 8'h61 && data <= 8'h66):
        nib = data[3:0] + 4'd9;
      default:
        hex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= 1'b0;
      hi    <= '0;
    end else if (rcv) begin
      if (hex && !phase) begin
        hi    <= nib;
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
      end
    end
  end

  assign byte_vld = rcv & hex & phase;
  assign byte_val = {hi, nib};
  assign bad      = rcv & ~hex;

endmodule

// File: rtl/mxv_cmd_ctrl.sv
// Frame parser: decodes FE LEN CMD payload EF frames
// into size updates, element pushes and start pulses.
module mxv_cmd_ctrl #(
  parameter int DW    = 8,
  parameter int MAX_N = 8,
  parameter int N_CH  = 4
) (
  input logic          clk,
  input logic          rst,
  mxv_cmd_ctrl_if.slave bus
);
  import mxv_pkg::*;

  localparam int SW = $clog2(MAX_N + 1);

  logic            bv;
  logic            bad;
  logic [7:0]      b;

  state_t          st;
  logic [7:0]      len_q;
  logic [7:0]      cmd_q;
  logic [7:0]      cnt;
  logic [SW-1:0]   size_q;
  logic [SW-1:0]   nsize;
  logic [SW-1:0]   col;
  logic [N_CH-1:0] ch_oh;
  logic [N_CH-1:0] ena_mask;
  logic [N_CH-1:0] push_m;
  logic [N_CH-1:0] ena_q;
  logic            push_v;
  logic            err_q;
  logic [DW-1:0]   val_q;

  logic [15:0]     req_len;
  logic            cmd_ok;
  logic            size_ok;
  logic            last;

  ascii_byte_asm u_asm (
    .clk      (clk),
    .rst      (rst),
    .rcv      (bus.rcv),
    .data     (bus.data),
    .byte_vld (bv),
    .byte_val (b),
    .bad      (bad)
  );

  // LEN must match exactly what the command implies
  always_comb begin
    req_len = '0;
    cmd_ok  = 1'b1;
    case (b)
      CMD_SIZE:  req_len = 16'd2;
      CMD_VEC:   req_len = 16'(size_q) + 16'd1;
      CMD_MAT:   req_len = 16'(size_q) * 16'(size_q)
                         + 16'd1;
      CMD_START: req_len = 16'd1;
      default:   cmd_ok  = 1'b0;
    endcase
    cmd_ok = cmd_ok && (req_len == {8'h00, len_q});
  end

  always_comb begin
    ena_mask = '0;
    for (int c = 0; c < N_CH; c++)
      ena_mask[c] = c < int'(size_q);
  end

  assign size_ok = (b != 8'd0)
                && ({24'd0, b} <= 32'(MAX_N));
  assign last = (cnt + 8'd1) == (len_q - 8'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= S_IDLE;
      len_q  <= '0;
      cmd_q  <= '0;
      cnt    <= '0;
      size_q <= SW'(MAX_N);
      nsize  <= '0;
      col    <= '0;
      ch_oh  <= N_CH'(1);
      push_v <= 1'b0;
      push_m <= '0;
      ena_q  <= '0;
      err_q  <= 1'b0;
      val_q  <= '0;
    end else begin
      push_v <= 1'b0;
      push_m <= '0;
      ena_q  <= '0;
      err_q  <= 1'b0;
      val_q  <= '0;
      case (st)
        S_IDLE: begin
          if (bv && b == HDR)
            st <= S_LEN;
        end
        S_LEN: begin
          if (bad) begin
            st    <= S_ERR;
            err_q <= 1'b1;
          end else if (bv) begin
            len_q <= b;
            st    <= S_CMD;
          end
        end
        S_CMD: begin
          if (bad || (bv && !cmd_ok)) begin
            st    <= S_ERR;
            err_q <= 1'b1;
          end else if (bv) begin
            cmd_q <= b;
            cnt   <= '0;
            col   <= '0;
            ch_oh <= N_CH'(1);
            st    <= (len_q == 8'd1) ? S_TRAIL
                                     : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (bad) begin
            st    <= S_ERR;
            err_q <= 1'b1;
          end else if (bv) begin
            cnt <= cnt + 8'd1;
            if (last)
              st <= S_TRAIL;
            case (cmd_q)
              CMD_SIZE: begin
                nsize <= SW'(b);
                if (!size_ok) begin
                  st    <= S_ERR;
                  err_q <= 1'b1;
                end
              end
              CMD_VEC: begin
                push_v <= 1'b1;
                val_q  <= DW'(b);
              end
              CMD_MAT: begin
                push_m <= ch_oh;
                val_q  <= DW'(b);
                // row wrap advances channel: row r -> r mod N_CH
                if (col == size_q - SW'(1)) begin
                  col   <= '0;
                  ch_oh <= (ch_oh << 1)
                         | (ch_oh >> (N_CH - 1));
                end else begin
                  col <= col + SW'(1);
                end
              end
              default: ;
            endcase
          end
        end
        S_TRAIL: begin
          if (bad || (bv && b != TRL)) begin
            st    <= S_ERR;
            err_q <= 1'b1;
          end else if (bv) begin
            st <= S_EXEC;
            if (cmd_q == CMD_SIZE)
              size_q <= nsize;
            if (cmd_q == CMD_START)
              ena_q <= ena_mask;
          end
        end
        S_EXEC: begin
          st <= (bv && b == HDR) ? S_LEN : S_IDLE;
        end
        S_ERR: begin
          if (bv && b == TRL)
            st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.push_vector = push_v;
  assign bus.push_matrix = push_m;
  assign bus.val         = val_q;
  assign bus.ena_proc    = ena_q;
  assign bus.size        = size_q;
  assign bus.busy        = (st != S_IDLE);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mxv_cmd_ctrl.sv
// Directed bench for mxv_cmd_ctrl with a frame-level
// reference model checked every cycle.
module tb_mxv_cmd_ctrl;
  localparam int DW    = 8;
  localparam int MAX_N = 8;
  localparam int N_CH  = 4;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mxv_cmd_ctrl_if #(
    .DW(DW), .MAX_N(MAX_N), .N_CH(N_CH)
  ) bus ();

  mxv_cmd_ctrl #(
    .DW(DW), .MAX_N(MAX_N), .N_CH(N_CH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int ntest = 0;
  int nfail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_phase, m_open, m_dead, m_exec;
  logic [3:0] m_hi;
  logic [7:0] m_q[$];
  int         m_size, m_pend;
  logic       e_pv, e_err;
  logic [3:0] e_pm, e_ena;
  logic [7:0] e_val;

  task automatic m_reset();
    m_phase = 0; m_open = 0; m_dead = 0; m_exec = 0;
    m_hi = '0; m_q.delete();
    m_size = MAX_N; m_pend = 0;
    e_pv = 0; e_err = 0; e_pm = '0; e_ena = '0;
    e_val = '0;
  endtask

  task automatic m_fail();
    e_err  = 1;
    m_dead = 1;
    m_open = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    int L, C, p, req, k, lim;
    if (m_dead) begin
      if (b == 8'hEF) m_dead = 0;
      return;
    end
    if (!m_open) begin
      if (b == 8'hFE) begin
        m_open = 1;
        m_q.delete();
      end
      return;
    end
    m_q.push_back(b);
    p = m_q.size();
    if (p == 1) return;
    L = int'(m_q[0]);
    C = int'(m_q[1]);
    if (p == 2) begin
      case (C)
        1: req = 2;
        2: req = m_size + 1;
        3: req = m_size * m_size + 1;
        4: req = 1;
        default: req = -1;
      endcase
      if (L != req) m_fail();
      return;
    end
    if (p <= L + 1) begin
      k = p - 3;
      case (C)
        1: if (b >= 1 && int'(b) <= MAX_N)
             m_pend = int'(b);
           else
             m_fail();
        2: begin e_pv = 1; e_val = b; end
        3: begin
          e_pm  = 4'(1 << ((k / m_size) % N_CH));
          e_val = b;
        end
        default: ;
      endcase
      return;
    end
    if (b == 8'hEF) begin
      m_open = 0;
      m_exec = 1;
      if (C == 1) m_size = m_pend;
      lim = (m_size < N_CH) ? m_size : N_CH;
      if (C == 4) e_ena = 4'((1 << lim) - 1);
    end else begin
      m_fail();
    end
  endtask

  task automatic m_char(input logic [7:0] c);
    logic [3:0] n;
    bit h;
    h = 1;
    n = '0;
    if (c >= "0" && c <= "9")
      n = 4'(c - 8'h30);
    else if (c >= "A" && c <= "F")
      n = 4'(c - 8'h41 + 8'd10);
    else if (c >= "a" && c <= "f")
      n = 4'(c - 8'h61 + 8'd10);
    else
      h = 0;
    if (!h) begin
      m_phase = 0;
      if (m_open) m_fail();
    end else if (!m_phase) begin
      m_hi = n;
      m_phase = 1;
    end else begin
      m_phase = 0;
      m_byte({m_hi, n});
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reset();
    end else begin
      e_pv = 0; e_err = 0; e_pm = '0; e_ena = '0;
      e_val = '0;
      m_exec = 0;
      if (bus.rcv) m_char(bus.data);
    end
  end

  // ---------------- compare + monitors ----------------
  logic [7:0] pv_log[$];
  logic [3:0] pm_log[$];
  logic [3:0] ena_log[$];
  int         err_cnt = 0;

  always @(negedge clk) begin
    chk("push_vector", 32'(bus.push_vector), 32'(e_pv));
    chk("push_matrix", 32'(bus.push_matrix), 32'(e_pm));
    chk("val", 32'(bus.val), 32'(e_val));
    chk("ena_proc", 32'(bus.ena_proc), 32'(e_ena));
    chk("size", 32'(bus.size), 32'(m_size));
    chk("busy", 32'(bus.busy),
        32'(m_open | m_dead | m_exec));
    chk("err", 32'(bus.err), 32'(e_err));
    if (bus.push_vector) pv_log.push_back(bus.val);
    if (|bus.push_matrix) pm_log.push_back(bus.push_matrix);
    if (|bus.ena_proc) ena_log.push_back(bus.ena_proc);
    if (bus.err) err_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  bit lc = 0;

  function automatic logic [7:0] hx(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + 8'(v);
    return (lc ? 8'h61 : 8'h41) + 8'(v) - 8'd10;
  endfunction

  task automatic put(input logic [7:0] c);
    @(negedge clk);
    bus.rcv  = 1'b1;
    bus.data = c;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rcv = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    put(hx(b[7:4]));
    put(hx(b[3:0]));
    idle(1);
  endtask

  task automatic send(input bq_t f);
    foreach (f[i]) send_byte(f[i]);
    idle(3);
  endtask

  task automatic clr();
    pv_log.delete();
    pm_log.delete();
    ena_log.delete();
    err_cnt = 0;
  endtask

  bq_t fq;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rcv  = 1'b0;
    bus.data = 8'h00;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_size", 32'(bus.size), 32'd8);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_val", 32'(bus.val), 32'd0);
    rst = 1'b1;
    idle(2);

    // set size 4
    clr();
    fq = {8'hFE, 8'h02, 8'h01, 8'h04, 8'hEF};
    send(fq);
    chk("sz4", 32'(bus.size), 32'd4);
    chk("sz4_err", 32'(err_cnt), 32'd0);

    // load vector, N=4
    clr();
    fq = {8'hFE, 8'h05, 8'h02,
          8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hEF};
    send(fq);
    chk("vec_n", 32'(pv_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("vec_val", 32'(pv_log[i]), 32'(8'h0A + i));
    chk("vec_err", 32'(err_cnt), 32'd0);

    // load matrix, N=4, lowercase hex
    clr();
    lc = 1;
    fq = {8'hFE, 8'h11, 8'h03};
    for (int i = 0; i < 16; i++) fq.push_back(8'(8'hA0 + i));
    fq.push_back(8'hEF);
    send(fq);
    lc = 0;
    chk("mat_n", 32'(pm_log.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      chk("mat_ch", 32'(pm_log[i]),
          32'(4'b0001 << (i / 4)));

    // N=2 then start
    clr();
    fq = {8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF};
    send(fq);
    fq = {8'hFE, 8'h01, 8'h04, 8'hEF};
    send(fq);
    chk("ena_n", 32'(ena_log.size()), 32'd1);
    chk("ena_v", 32'(ena_log[0]), 32'h3);

    // size 9 rejected, size unchanged, next ok
    clr();
    fq = {8'hFE, 8'h02, 8'h01, 8'h09, 8'hEF};
    send(fq);
    chk("sz9_err", 32'(err_cnt), 32'd1);
    chk("sz9_size", 32'(bus.size), 32'd2);
    fq = {8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF};
    send(fq);
    chk("sz3", 32'(bus.size), 32'd3);

    // bad LEN, unknown CMD, bad trailer
    clr();
    fq = {8'hFE, 8'h03, 8'h01, 8'h04, 8'hEF};
    send(fq);
    fq = {8'hFE, 8'h01, 8'h05, 8'hEF};
    send(fq);
    fq = {8'hFE, 8'h01, 8'h04, 8'hEE, 8'hEF};
    send(fq);
    chk("bad3_err", 32'(err_cnt), 32'd3);
    chk("bad3_ena", 32'(ena_log.size()), 32'd0);

    // 'G' inside a frame; junk in idle ignored
    clr();
    send_byte(8'hFE);
    send_byte(8'h04);
    put("G");
    idle(2);
    chk("g_err", 32'(err_cnt), 32'd1);
    send_byte(8'hEF);
    put(" "); put(8'h0A); idle(2);
    chk("junk_err", 32'(err_cnt), 32'd1);
    chk("junk_busy", 32'(bus.busy), 32'd0);

    // back-to-back chars through EXEC
    clr();
    put("F"); put("E"); put("0"); put("1");
    put("0"); put("4"); put("E"); put("F");
    put("z"); put("F"); put("E"); put("0");
    put("1"); put("0"); put("4"); put("E");
    put("F");
    idle(3);
    chk("b2b_ena", 32'(ena_log.size()), 32'd2);
    chk("b2b_err", 32'(err_cnt), 32'd0);

    // N=8 matrix: rows 4..7 wrap onto channels 0..3
    clr();
    fq = {8'hFE, 8'h02, 8'h01, 8'h08, 8'hEF};
    send(fq);
    fq = {8'hFE, 8'h41, 8'h03};
    for (int i = 0; i < 64; i++) fq.push_back(8'(i));
    fq.push_back(8'hEF);
    send(fq);
    chk("m8_n", 32'(pm_log.size()), 32'd64);
    chk("m8_r4", 32'(pm_log[32]), 32'h1);
    chk("m8_r7", 32'(pm_log[63]), 32'h8);
    fq = {8'hFE, 8'h01, 8'h04, 8'hEF};
    send(fq);
    chk("m8_ena", 32'(ena_log[0]), 32'hF);

    // N=1 matrix
    clr();
    fq = {8'hFE, 8'h02, 8'h01, 8'h01, 8'hEF};
    send(fq);
    fq = {8'hFE, 8'h02, 8'h03, 8'h5A, 8'hEF};
    send(fq);
    chk("m1_n", 32'(pm_log.size()), 32'd1);
    chk("m1_ch", 32'(pm_log[0]), 32'h1);

    // reset mid-payload
    clr();
    fq = {8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF};
    send(fq);
    send_byte(8'hFE);
    send_byte(8'h04);
    send_byte(8'h02);
    send_byte(8'h11);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_size", 32'(bus.size), 32'd8);
    chk("mr_pv", 32'(bus.push_vector), 32'd0);
    chk("mr_val", 32'(bus.val), 32'd0);
    chk("mr_err", 32'(err_cnt), 32'd0);
    rst = 1'b1;
    idle(2);
    fq = {8'hFE, 8'h02, 8'h01, 8'h05, 8'hEF};
    send(fq);
    chk("mr_next", 32'(bus.size), 32'd5);
    chk("mr_err2", 32'(err_cnt), 32'd0);

    idle(2);
    $display("[TB] %0d tests run, %0d failed",
             ntest, nfail);
    $finish;
  end

endmodule

// File: doc/mxv_cmd_ctrl.md
MXV_CMD_CTRL -- requirements
Module: mxv_cmd_ctrl

Interface
REQ-001 Parameter DW, default 8, width of one matrix/vector element.
REQ-002 Parameter MAX_N, default 8, largest supported matrix dimension N (N x N matrix, N-element vector).
REQ-003 Parameter N_CH, default 4, number of processing channels.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  single clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 rcv  in  1  one-cycle strobe: data holds a new UART character.
REQ-008 data  in  8  ASCII character.
REQ-009 push_vector  out  1  one-cycle pulse: val is a vector element.
REQ-010 push_matrix  out  N_CH  one-hot pulse: val is a matrix element for that channel.
REQ-011 val  out  DW  element value, valid with any push.
REQ-012 ena_proc  out  N_CH  one-cycle start pulse per channel.
REQ-013 size  out  clog2(MAX_N+1)  current N.
REQ-014 busy  out  1  high while a frame is open (any state except IDLE).
REQ-015 err  out  1  one-cycle pulse on frame error.

Function
REQ-016 Two consecutive hex characters ('0'-'9', 'A'-'F', 'a'-'f') SHALL form one byte, high nibble first; the nibble phase SHALL clear on each completed byte.
REQ-017 A non-hex character SHALL clear the nibble phase; in IDLE it is ignored, in any other state it SHALL force ERR.
REQ-018 Frame = 0xFE, LEN, CMD, payload, 0xEF; LEN SHALL equal payload byte count + 1.
REQ-019 FSM states: IDLE, LEN, CMD, PAYLOAD, TRAIL, EXEC, ERR.
REQ-020 IDLE -> LEN on byte 0xFE; all other bytes SHALL be ignored.
REQ-021 LEN -> CMD always; the LEN byte SHALL be stored.
REQ-022 CMD 0x01 (set size): payload 1 byte, value 1..MAX_N, else ERR; size SHALL update only in EXEC.
REQ-023 CMD 0x02 (load vector): payload N bytes; each byte SHALL drive push_vector with val = byte in the cycle after the low-nibble rcv.
REQ-024 CMD 0x03 (load matrix): payload N*N bytes, row-major; an element of row r SHALL pulse push_matrix[r mod N_CH], same latency as REQ-023.
REQ-025 CMD 0x04 (start): payload 0 bytes; EXEC SHALL pulse ena_proc[c] for every channel c < min(N, N_CH).
REQ-026 An unknown CMD, or a LEN different from the one REQ-022..025 require, SHALL force ERR at the CMD byte.
REQ-027 PAYLOAD SHALL count bytes with a counter that is cleared on entry; reaching LEN-1 SHALL go to TRAIL, and LEN-1 = 0 SHALL skip directly to TRAIL.
REQ-028 TRAIL: byte 0xEF -> EXEC; any other byte -> ERR.
REQ-029 EXEC SHALL last exactly one cycle, then go to IDLE; an rcv during EXEC SHALL be processed as a normal character in IDLE context.
REQ-030 ERR: err SHALL pulse on the entry cycle; the FSM SHALL discard characters until byte 0xEF, then go to IDLE.
REQ-031 Elements already pushed before an error SHALL NOT be retracted; err alone flags the fault.
REQ-032 val SHALL be DW bits; if DW > 8 it is zero-extended, if DW < 8 the LSBs are kept.
REQ-033 At most one push output SHALL be high in any cycle.

Reset
REQ-034 Reset SHALL force state IDLE, nibble phase high-first, counters 0, size = MAX_N, and all pulse outputs, val, busy and err to 0.
REQ-035 Reset mid-frame SHALL abandon the frame with no EXEC action and no err pulse.

Structure
REQ-036 Package mxv_pkg SHALL hold the header/trailer constants (0xFE/0xEF), the command codes 0x01-0x04, and the FSM state enum.
REQ-037 One sub-module, ascii_byte_asm, SHALL perform ASCII-pair-to-byte assembly, outputting a byte strobe and a bad-character strobe.

Verification
REQ-038 Frame "FE 02 01 04 EF" -> size=4 one cycle after the trailer; no err.
REQ-039 N=4, frame "FE 05 02 0A 0B 0C 0D EF" -> four push_vector pulses with val 0x0A..0x0D; no err.
REQ-040 N=4, DW=8, N_CH=4, load matrix of 16 bytes -> push_matrix one-hot cycles through channels 0,1,2,3, one row per channel, 4 pulses each.
REQ-041 N=2, frame "FE 01 04 EF" -> ena_proc = 4'b0011 for one cycle.
REQ-042 "FE 02 01 09 EF" with MAX_N=8 -> err pulse, size unchanged; the next valid frame is accepted.
REQ-043 'G' inside a frame -> err; reset asserted mid-payload -> IDLE, all outputs 0, no err.
